// File: rtl/game_defs_pkg.sv
// game_defs: screen geometry, coordinate type and player FSM encoding shared by game logic
package game_defs;
    localparam int COORD_W = 10;
    localparam int SCREEN_W = 640;
    localparam int PLAYER_Y = 440;
    typedef logic [COORD_W-1:0] coord_t;
    typedef enum logic [1:0] {ALIVE, HIT, OVER} state_t;
endpackage

// File: rtl/player_bullet.sv
// player_bullet: launch, upward flight and hit clear of the single player bullet
module player_bullet
    import game_defs::*;
#(
    parameter int BULLET_H = 8,
    parameter int BULLET_STEP = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   tick,
    input  logic   launch,
    input  coord_t start_x,
    input  logic   bullet_hit,
    output coord_t bullet_x,
    output coord_t bullet_y,
    output logic   bullet_active
);
    localparam coord_t START_Y = coord_t'(PLAYER_Y - BULLET_H);
    localparam coord_t STEP = coord_t'(BULLET_STEP);
    // a hit clears before any launch or advance; the bullet retires once it cannot rise a full step
    always_ff @(posedge clk) begin
        if (rst) begin
            bullet_active <= 1'b0;
            bullet_x <= '0;
            bullet_y <= '0;
        end else if (bullet_hit) begin
            bullet_active <= 1'b0;
        end else if (launch) begin
            bullet_active <= 1'b1;
            bullet_x <= start_x;
            bullet_y <= START_Y;
        end else if (tick && bullet_active) begin
            if (bullet_y < STEP) bullet_active <= 1'b0;
            else bullet_y <= bullet_y - STEP;
        end
    end
endmodule

// File: rtl/player_ctrl.sv
// player_ctrl: cannon movement, fire request, lives and alive/exploding/game-over FSM
module player_ctrl
    import game_defs::*;
#(
    parameter int PLAYER_W = 26,
    parameter int X_INIT = 307,
    parameter int PLAYER_STEP = 2,
    parameter int BULLET_H = 8,
    parameter int BULLET_STEP = 4,
    parameter int LIVES = 3,
    parameter int EXPLODE_TICKS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       left,
    input  logic       right,
    input  logic       shoot,
    input  logic       bullet_hit,
    input  logic       player_hit,
    output coord_t     player_x,
    output coord_t     bullet_x,
    output coord_t     bullet_y,
    output logic       bullet_active,
    output logic       fire_pulse,
    output logic [2:0] lives,
    output logic       exploding,
    output logic       game_over
);
    localparam int CW = $clog2(EXPLODE_TICKS + 1);
    localparam coord_t X_MAX = coord_t'(SCREEN_W - PLAYER_W);
    localparam coord_t STEP = coord_t'(PLAYER_STEP);
    state_t state, state_n;
    coord_t x_n;
    logic [2:0] lives_n;
    logic [CW-1:0] cnt, cnt_n;
    logic shoot_q, fire_req, launch, alive;
    assign alive = state == ALIVE;
    assign launch = alive && tick && !player_hit && !bullet_hit && fire_req && !bullet_active;
    assign exploding = state == HIT;
    assign game_over = state == OVER;
    // state, position, lives, explosion timer and fire edge registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ALIVE;
            player_x <= coord_t'(X_INIT);
            lives <= 3'(LIVES);
            cnt <= '0;
            shoot_q <= 1'b0;
            fire_req <= 1'b0;
            fire_pulse <= 1'b0;
        end else begin
            state <= state_n;
            player_x <= x_n;
            lives <= lives_n;
            cnt <= cnt_n;
            shoot_q <= shoot;
            fire_req <= (!alive || tick) ? 1'b0 : fire_req | (shoot & ~shoot_q);
            fire_pulse <= launch;
        end
    end
    // next state: hit beats a same-cycle tick; explosion ends on the tick that sees cnt==1
    always_comb begin
        state_n = state;
        x_n = player_x;
        lives_n = lives;
        cnt_n = cnt;
        case (state)
            ALIVE: begin
                if (player_hit) begin
                    state_n = HIT;
                    lives_n = lives - 3'd1;
                    cnt_n = CW'(EXPLODE_TICKS);
                end else if (tick && left && !right) begin
                    x_n = (player_x < STEP) ? '0 : player_x - STEP;
                end else if (tick && right && !left) begin
                    x_n = (player_x > X_MAX - STEP) ? X_MAX : player_x + STEP;
                end
            end
            HIT: begin
                if (tick) begin
                    cnt_n = cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state_n = (lives == 3'd0) ? OVER : ALIVE;
                        x_n = coord_t'(X_INIT);
                    end
                end
            end
            default: ;
        endcase
    end
    player_bullet #(.BULLET_H(BULLET_H), .BULLET_STEP(BULLET_STEP)) u_bullet (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .launch(launch),
        .start_x(player_x + coord_t'(PLAYER_W / 2)),
        .bullet_hit(bullet_hit || (alive && player_hit)),
        .bullet_x(bullet_x),
        .bullet_y(bullet_y),
        .bullet_active(bullet_active)
    );
endmodule
